sv_offset_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed-constant 128-bit "in + constant" cosim block.
- Adds a programmable offset to each input beat. Supports wrap or saturating arithmetic per beat.
- Carries results through a STAGES-deep elastic valid/ready pipeline with backpressure.
- Used as a sequential cosim target that exercises define-driven defaults, runtime reconfiguration and stall handling.

---
 rtl/sv_offset_pipe.sv | 105 ++++++++++
 tb/tb_sv_offset_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sv_offset_pipe.sv
// sv_offset_pipe: adds a programmable offset to each input beat, with wrap or
// saturating arithmetic chosen per beat. Results travel through an elastic
// valid/ready pipeline STAGES deep, which absorbs backpressure from downstream.
module sv_offset_pipe #(
    parameter int               WIDTH  = 128,
    parameter int               STAGES = 2,
    parameter logic [WIDTH-1:0] OFFSET = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_offset,
    output logic [WIDTH-1:0] cur_offset,
    output logic [31:0]      beat_cnt
);

    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_ovf;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [STAGES-1:0] can_accept;
    logic              tail_full;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  offset_q;
    logic [31:0]       cnt_q;

    // The offset in use is always the registered value, so a cfg write that lands
    // on the same edge as an accept only affects later beats.
    assign sum    = {1'b0, in_data} + {1'b0, offset_q};
    assign result = (in_sat && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];

    // A stage can take a beat when it or any stage after it has room, or when the
    // output is being drained. Walking from the tail keeps the chain acyclic.
    always_comb begin
        can_accept = '0;
        tail_full  = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            tail_full     = tail_full & stage_valid[i];
            can_accept[i] = out_ready | ~tail_full;
        end
    end

    assign in_ready   = rst_n & can_accept[0];
    assign out_valid  = stage_valid[STAGES-1];
    assign out_data   = stage_data[STAGES-1];
    assign out_ovf    = stage_ovf[STAGES-1];
    assign cur_offset = offset_q;
    assign beat_cnt   = cnt_q;

    // Pipeline registers: each stage loads from its predecessor whenever it can
    // accept, otherwise it holds its beat so the output stays stable under stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= '0;
            stage_ovf   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            if (can_accept[0]) begin
                stage_valid[0] <= in_valid;
                if (in_valid) begin
                    stage_data[0] <= result;
                    stage_ovf[0]  <= sum[WIDTH];
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (can_accept[i]) begin
                    stage_valid[i] <= stage_valid[i-1];
                    if (stage_valid[i-1]) begin
                        stage_data[i] <= stage_data[i-1];
                        stage_ovf[i]  <= stage_ovf[i-1];
                    end
                end
            end
        end
    end

    // Offset register, reloaded from cfg_offset on request; reset wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset_q <= OFFSET;
        end else if (cfg_we) begin
            offset_q <= cfg_offset;
        end
    end

    // Delivered-beat counter, sticking at its maximum until the next reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_sv_offset_pipe.sv
// tb_sv_offset_pipe: directed and randomised checks of sv_offset_pipe against a
// queue-based reference model of the offset adder and its delivery order.
module tb_sv_offset_pipe;

    localparam int              W   = 128;
    localparam int              S   = 2;
    localparam logic [W-1:0]    OFF = 3;
    localparam logic [W-1:0]    ALL = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_sat;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_ovf;
    logic          cfg_we;
    logic [W-1:0]  cfg_offset;
    logic [W-1:0]  cur_offset;
    logic [31:0]   beat_cnt;

    int            checks = 0;
    int            errors = 0;

    logic [W:0]    exp_q [$];
    logic [W-1:0]  m_off = OFF;
    logic [31:0]   m_cnt = '0;
    logic          hold_pending = 1'b0;
    logic [W:0]    held;

    sv_offset_pipe #(.WIDTH(W), .STAGES(S), .OFFSET(OFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sat     (in_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .cfg_we     (cfg_we),
        .cfg_offset (cfg_offset),
        .cur_offset (cur_offset),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    // Expected {ovf, data}: overflow means the operand exceeds the headroom left
    // by the offset; saturation pins the result to all ones.
    function automatic logic [W:0] model(input logic [W-1:0] d, input logic sat,
                                         input logic [W-1:0] off);
        logic          ovf;
        logic [W-1:0]  res;
        ovf = (d > (ALL - off));
        res = (ovf && sat) ? ALL : W'(d + off);
        return {ovf, res};
    endfunction

    task automatic checkOutput(input string tag, input logic [159:0] obs,
                               input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [W-1:0] d,
                                 input logic sat, input logic ordy, input logic we,
                                 input logic [W-1:0] off);
        rst_n      = rst;
        in_valid   = v;
        in_data    = d;
        in_sat     = sat;
        out_ready  = ordy;
        cfg_we     = we;
        cfg_offset = off;
    endtask

    // One clock: check at the falling edge, update the model for the coming
    // rising edge, then return 1 time unit after that edge.
    task automatic tick();
        logic       acc;
        logic       emt;
        logic [W:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        emt = out_valid && out_ready;
        checkOutput("beat_cnt", beat_cnt, m_cnt);
        checkOutput("cur_offset", cur_offset, m_off);
        if (!rst_n) checkOutput("in_ready_in_reset", in_ready, 0);
        if (hold_pending) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_data", {out_ovf, out_data}, held);
        end
        hold_pending = rst_n && out_valid && !out_ready;
        held         = {out_ovf, out_data};
        if (!rst_n) begin
            exp_q.delete();
            m_off = OFF;
            m_cnt = '0;
        end else begin
            if (emt) begin
                checkOutput("emit_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("result", {out_ovf, out_data}, e);
                end
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
            if (acc) exp_q.push_back(model(in_data, in_sat, m_off));
            if (cfg_we) m_off = cfg_offset;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            n_acc;
        logic [W-1:0]  rd;
        int            budget;

        // Reset
        applyStimulus(0, 0, '0, 0, 1, 1, 77);
        tick();
        tick();
        applyStimulus(1, 0, '0, 0, 1, 0, '0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", {out_ovf, out_data}, 0);
        checkOutput("reset_offset", cur_offset, 3);
        tick();

        // Single beat 5 -> 8, latency of two edges
        applyStimulus(1, 1, 5, 0, 1, 0, '0);
        tick();
        applyStimulus(1, 0, '0, 0, 1, 0, '0);
        checkOutput("lat_not_early", out_valid, 0);
        tick();
        checkOutput("lat_valid", out_valid, 1);
        checkOutput("lat_data", {out_ovf, out_data}, 8);
        tick();
        tick();
        checkOutput("single_cnt", beat_cnt, 1);

        // Ten back-to-back beats, outputs on consecutive cycles
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, W'(i), 0, 1, 0, '0);
            checkOutput("b2b_in_ready", in_ready, 1);
            if (i >= 2) checkOutput("b2b_out_valid", out_valid, 1);
            tick();
        end
        applyStimulus(1, 0, '0, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("b2b_cnt", beat_cnt, 11);

        // All-ones operand, wrap then saturate
        applyStimulus(1, 1, ALL, 0, 1, 0, '0);
        tick();
        applyStimulus(1, 1, ALL, 1, 1, 0, '0);
        tick();
        applyStimulus(1, 0, '0, 0, 1, 0, '0);
        checkOutput("wrap_beat", {out_ovf, out_data}, {1'b1, W'(2)});
        tick();
        checkOutput("sat_beat", {out_ovf, out_data}, {1'b1, ALL});
        tick();

        // Stall with a continuous stream, then release
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, W'(20 + i), 0, 0, 0, '0);
            if (in_ready) n_acc++;
            tick();
        end
        checkOutput("stall_accepts", n_acc, S);
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_head", out_data, 23);
        applyStimulus(1, 0, '0, 0, 1, 0, '0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("stall_drained", exp_q.size(), 0);

        // Offset write on the same edge as an accept
        applyStimulus(1, 1, 1, 0, 1, 1, 100);
        tick();
        applyStimulus(1, 1, 1, 0, 1, 0, '0);
        tick();
        applyStimulus(1, 0, '0, 0, 1, 0, '0);
        checkOutput("cfg_old_offset", out_data, 4);
        tick();
        checkOutput("cfg_new_offset", out_data, 101);
        tick();

        // Reset with two beats in flight
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, W'(50 + i), 0, 0, 0, '0);
            tick();
        end
        applyStimulus(0, 0, '0, 0, 0, 0, '0);
        tick();
        applyStimulus(1, 0, '0, 0, 1, 0, '0);
        checkOutput("post_reset_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("post_reset_offset", cur_offset, 3);

        // Randomised traffic, stalls and reconfiguration
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(3, 0) == 0) rd[W-1:32] = '1;
            applyStimulus(1, ($urandom_range(3, 0) != 0), rd, $urandom_range(1, 0),
                          ($urandom_range(9, 0) < 7), ($urandom_range(19, 0) == 0),
                          ($urandom_range(1, 0) == 1) ? W'($urandom_range(1000, 0))
                                                      : {$urandom, $urandom, $urandom, $urandom});
            tick();
        end

        // Bounded drain
        applyStimulus(1, 0, '0, 0, 1, 0, '0);
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        tick();
        checkOutput("final_drain", exp_q.size(), 0);
        checkOutput("final_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
